// File: rtl/termobloco_reservatorio_pkg.sv
// termobloco_reservatorio_pkg: shared coffee-machine encodings and reservoir defaults
package termobloco_reservatorio_pkg;
    typedef enum logic [2:0] {
        FSM_DESLIGADO  = 3'b000,
        FSM_AQUECENDO  = 3'b001,
        FSM_PRONTO     = 3'b010,
        FSM_MOAGEM     = 3'b011,
        FSM_BOMBEANDO  = 3'b100,
        FSM_FINALIZADO = 3'b101,
        FSM_ERRO       = 3'b110
    } fsm_state_t;
    typedef enum logic [1:0] {
        OFF     = 2'b00,
        HEATING = 2'b01,
        READY   = 2'b10
    } heater_t;
    localparam int LEVEL_W_DEF   = 4;
    localparam int LEVEL_MAX_DEF = 15;
endpackage

// File: rtl/termobloco_reservatorio_if.sv
// termobloco_reservatorio_if: control FSM <-> plant signals; master is the FSM, slave the plant
interface termobloco_reservatorio_if
    import termobloco_reservatorio_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
);
    logic               Power;
    logic               BombaAgua;
    logic               refill;
    logic               contadorTermobloco;
    logic               Reservatorio;
    logic [LEVEL_W-1:0] NivelAgua;
    logic               ErroSeco;
    modport master (
        output Power, BombaAgua, refill,
        input  contadorTermobloco, Reservatorio, NivelAgua, ErroSeco
    );
    modport slave (
        input  Power, BombaAgua, refill,
        output contadorTermobloco, Reservatorio, NivelAgua, ErroSeco
    );
endinterface

// File: rtl/termobloco_reservatorio_nivel.sv
// reservatorio_nivel: saturating water-level register with availability and sticky dry-pump flag
module reservatorio_nivel #(
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_MAX   = 15,
    parameter int DOSE        = 1,
    parameter int REFILL_STEP = 3,
    parameter int LOW_LEVEL   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pump,
    input  logic               refill,
    output logic [LEVEL_W-1:0] level,
    output logic               available,
    output logic               dry_error
);
    localparam int SW = LEVEL_W + 2;
    localparam logic signed [SW-1:0] DOSE_S = SW'(DOSE);
    localparam logic signed [SW-1:0] STEP_S = SW'(REFILL_STEP);
    localparam logic signed [SW-1:0] MAX_S  = SW'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]   MAX_L  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]   LOW_L  = LEVEL_W'(LOW_LEVEL);
    logic signed [SW-1:0] sum;
    logic [LEVEL_W-1:0]   level_n;
    // Two guard bits keep the signed sum from wrapping before it is clamped.
    always_comb begin
        sum     = $signed({2'b00, level}) - (pump ? DOSE_S : '0) + (refill ? STEP_S : '0);
        level_n = sum[SW-1] ? '0 : (sum > MAX_S) ? MAX_L : sum[LEVEL_W-1:0];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            level     <= MAX_L;
            available <= 1'b1;
            dry_error <= 1'b0;
        end else begin
            level     <= level_n;
            available <= level_n > LOW_L;
            dry_error <= !refill && (dry_error || (pump && level == '0));
        end
    end
endmodule

// File: rtl/termobloco_reservatorio.sv
// termobloco_reservatorio: thermoblock pre-heat timer and reservoir plant model
// answering the coffee-machine control FSM.
module termobloco_reservatorio
    import termobloco_reservatorio_pkg::*;
#(
    parameter int HEAT_CYCLES = 5,
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int DOSE        = 1,
    parameter int REFILL_STEP = 3,
    parameter int LOW_LEVEL   = 2
) (
    input logic clock,
    input logic reset,
    termobloco_reservatorio_if.slave bus
);
    localparam logic [3:0] HEAT_N = 4'(HEAT_CYCLES);
    heater_t    state, state_n;
    logic [3:0] count, count_n;
    logic       heat, heat_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OFF;
            count <= '0;
            heat  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            heat  <= heat_n;
        end
    end
    // Losing power always restarts the full pre-heat on the next power-up.
    always_comb begin
        state_n = state;
        count_n = count;
        heat_n  = heat;
        if (!bus.Power) begin
            state_n = OFF;
            count_n = '0;
            heat_n  = 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state_n = HEATING;
                    count_n = HEAT_N;
                    heat_n  = 1'b1;
                end
                HEATING: begin
                    state_n = (count == 4'd1) ? READY : HEATING;
                    count_n = (count == 4'd1) ? 4'd0 : count - 4'd1;
                    heat_n  = count != 4'd1;
                end
                READY: heat_n = 1'b0;
                default: begin
                    state_n = OFF;
                    count_n = '0;
                    heat_n  = 1'b0;
                end
            endcase
        end
    end
    assign bus.contadorTermobloco = heat;
    reservatorio_nivel #(
        .LEVEL_W(LEVEL_W), .LEVEL_MAX(LEVEL_MAX), .DOSE(DOSE),
        .REFILL_STEP(REFILL_STEP), .LOW_LEVEL(LOW_LEVEL)
    ) nivel (
        .clock(clock),
        .reset(reset),
        .pump(bus.BombaAgua),
        .refill(bus.refill),
        .level(bus.NivelAgua),
        .available(bus.Reservatorio),
        .dry_error(bus.ErroSeco)
    );
endmodule

// File: tb/tb_termobloco_reservatorio.sv
// tb_termobloco_reservatorio: directed steps with a scoreboard of expected plant outputs
module tb_termobloco_reservatorio;
    import termobloco_reservatorio_pkg::*;
    typedef struct {
        string      tag;
        logic       flag;
        logic [3:0] lvl;
        logic       res;
        logic       erro;
    } exp_t;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    termobloco_reservatorio_if #(.LEVEL_W(4)) bus ();
    termobloco_reservatorio dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic rs, input logic p, input logic b,
                        input logic r, input logic ef, input logic [3:0] el,
                        input logic er, input logic ee);
        exp_t e;
        @(negedge clock);
        reset = rs;
        bus.Power = p;
        bus.BombaAgua = b;
        bus.refill = r;
        e.tag = tag; e.flag = ef; e.lvl = el; e.res = er; e.erro = ee;
        q.push_back(e);
        @(posedge clock);
        #1;
        e = q.pop_front();
        chk({e.tag, ".flag"}, {3'b0, bus.contadorTermobloco}, {3'b0, e.flag});
        chk({e.tag, ".nivel"}, bus.NivelAgua, e.lvl);
        chk({e.tag, ".res"}, {3'b0, bus.Reservatorio}, {3'b0, e.res});
        chk({e.tag, ".erro"}, {3'b0, bus.ErroSeco}, {3'b0, e.erro});
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        bus.Power = 1'b0; bus.BombaAgua = 1'b0; bus.refill = 1'b0;
        for (int i = 0; i < 2; i++) step($sformatf("reset%0d", i), 1, 0, 0, 0, 0, 15, 1, 0);
        chk("reset.state", {2'b0, dut.state}, {2'b0, OFF});
        // power-up: flag high exactly 5 cycles
        for (int i = 0; i < 5; i++) step($sformatf("heat%0d", i), 0, 1, 0, 0, 1, 15, 1, 0);
        for (int i = 0; i < 2; i++) step($sformatf("ready%0d", i), 0, 1, 0, 0, 0, 15, 1, 0);
        chk("ready.state", {2'b0, dut.state}, {2'b0, READY});
        // power drop mid-heat, then full re-heat
        step("off", 0, 0, 0, 0, 0, 15, 1, 0);
        for (int i = 0; i < 3; i++) step($sformatf("part%0d", i), 0, 1, 0, 0, 1, 15, 1, 0);
        step("drop", 0, 0, 0, 0, 0, 15, 1, 0);
        for (int i = 0; i < 5; i++) step($sformatf("reheat%0d", i), 0, 1, 0, 0, 1, 15, 1, 0);
        step("reready", 0, 1, 0, 0, 0, 15, 1, 0);
        // drain 15 -> 2, Reservatorio drops with level 2
        for (int i = 1; i <= 13; i++)
            step($sformatf("drain%0d", i), 0, 1, 1, 0, 0, 4'(15 - i), (15 - i) > 2, 0);
        step("drain14", 0, 1, 1, 0, 0, 1, 0, 0);
        step("drain15", 0, 1, 1, 0, 0, 0, 0, 0);
        step("dry", 0, 1, 1, 0, 0, 0, 0, 1);
        step("dry_hold", 0, 1, 0, 0, 0, 0, 0, 1);
        // refill saturates at 15, clears ErroSeco at once
        for (int i = 1; i <= 6; i++)
            step($sformatf("refill%0d", i), 0, 1, 0, 1, 0, (i >= 5) ? 4'd15 : 4'(3 * i), 1, 0);
        // simultaneous pump and refill
        for (int i = 1; i <= 5; i++) step($sformatf("to10_%0d", i), 0, 1, 1, 0, 0, 4'(15 - i), 1, 0);
        step("both10", 0, 1, 1, 1, 0, 12, 1, 0);
        step("fill15", 0, 1, 0, 1, 0, 15, 1, 0);
        step("to14", 0, 1, 1, 0, 0, 14, 1, 0);
        step("both14", 0, 1, 1, 1, 0, 15, 1, 0);
        // reset during HEATING with level 4
        for (int i = 1; i <= 11; i++) step($sformatf("to4_%0d", i), 0, 0, 1, 0, 0, 4'(15 - i), 1, 0);
        step("dry_arm", 0, 1, 0, 0, 1, 4, 1, 0);
        step("heat_mid", 0, 1, 0, 0, 1, 4, 1, 0);
        chk("mid.state", {2'b0, dut.state}, {2'b0, HEATING});
        step("rst_mid", 1, 1, 1, 0, 0, 15, 1, 0);
        chk("rst.state", {2'b0, dut.state}, {2'b0, OFF});
        for (int i = 0; i < 5; i++) step($sformatf("post%0d", i), 0, 1, 0, 0, 1, 15, 1, 0);
        step("post_ready", 0, 1, 0, 0, 0, 15, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
